// File: rtl/pipe_chain_if.sv
// Valid/ready payload channel used on both sides of pipe_chain.
// master drives valid/data, slave drives ready.
interface pipe_chain_if #(
  parameter int unsigned WIDTH = 16
);
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_chain.sv
// Elastic chain of STAGES payload registers with per-stage flush and bubble collapse.
// Define PIPE_CHAIN_PERF_EN to add saturating perf_stall_cnt / perf_kill_cnt outputs.
module pipe_chain #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pipe_chain_if.slave                 in_bus,
  pipe_chain_if.master                out_bus,
  input  logic [STAGES-1:0]           flush_mask,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`ifdef PIPE_CHAIN_PERF_EN
  ,
  output logic [15:0]                 perf_stall_cnt,
  output logic [15:0]                 perf_kill_cnt
`endif
);

  localparam int unsigned OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] v_nxt;
  logic [STAGES-1:0] adv;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  d [STAGES];
  logic              load0;

  function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] bits);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      n = n + OCC_W'(bits[k]);
    end
    return n;
  endfunction

  // Ready ripples from the output back to stage 0 through a scalar so the
  // chain never reads its own vector inside the block.
  always_comb begin
    logic r;
    r           = out_bus.ready;
    rdy         = '0;
    rdy[STAGES] = r;
    for (int unsigned i = 0; i < STAGES; i++) begin
      r                   = ~v[STAGES-1-i] | flush_mask[STAGES-1-i] | r;
      rdy[STAGES-1-i]     = r;
    end
  end

  always_comb begin
    adv      = v & ~flush_mask & rdy[STAGES:1];
    load0    = in_bus.valid & rdy[0];
    v_nxt    = '0;
    v_nxt[0] = load0 | (v[0] & ~adv[0] & ~flush_mask[0]);
    for (int unsigned k = 1; k < STAGES; k++) begin
      v_nxt[k] = adv[k-1] | (v[k] & ~adv[k] & ~flush_mask[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v         <= '0;
      occupancy <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        d[k] <= '0;
      end
    end else begin
      v         <= v_nxt;
      occupancy <= popcount(v_nxt);
      if (load0) begin
        d[0] <= in_bus.data;
      end
      for (int unsigned k = 1; k < STAGES; k++) begin
        if (adv[k-1]) begin
          d[k] <= d[k-1];
        end
      end
    end
  end

  assign in_bus.ready  = rdy[0];
  assign out_bus.valid = v[STAGES-1] & ~flush_mask[STAGES-1];
  assign out_bus.data  = d[STAGES-1];

`ifdef PIPE_CHAIN_PERF_EN
  logic [16:0] kill_sum;

  always_comb begin
    kill_sum = {1'b0, perf_kill_cnt} + 17'(popcount(v & flush_mask));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cnt <= '0;
      perf_kill_cnt  <= '0;
    end else begin
      if (in_bus.valid && !rdy[0] && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      end
      perf_kill_cnt <= kill_sum[16] ? '1 : kill_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_pipe_chain.sv
// Self-checking bench for pipe_chain: directed scenarios plus randomized traffic
// against an item-list reference model.
module tb_pipe_chain;
  localparam int S  = 4;
  localparam int W  = 16;
  localparam int OW = $clog2(S + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [S-1:0]  flush_mask;
  logic [OW-1:0] occupancy;

  pipe_chain_if #(.WIDTH(W)) in_if ();
  pipe_chain_if #(.WIDTH(W)) out_if ();

`ifdef PIPE_CHAIN_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_kill_cnt;
`endif

  pipe_chain #(.STAGES(S), .WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_bus     (in_if),
    .out_bus    (out_if),
    .flush_mask (flush_mask),
    .occupancy  (occupancy)
`ifdef PIPE_CHAIN_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_kill_cnt  (perf_kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: slot k holds an item or is empty; items move downstream
  // into free slots, processed from the output end first.
  logic         mv [S];
  logic [W-1:0] md [S];
  int           m_stall = 0;
  int           m_kill  = 0;
  logic         cur_iv, cur_ordy;
  logic [W-1:0] cur_id;
  logic [S-1:0] cur_fm;
  logic [W-1:0] seen [$];

  function automatic void model_reset();
    for (int k = 0; k < S; k++) begin
      mv[k] = 1'b0;
      md[k] = '0;
    end
  endfunction

  function automatic logic model_advance(input logic commit);
    logic         v [S];
    logic [W-1:0] dd [S];
    logic         free0;
    v  = mv;
    dd = md;
    for (int k = S - 1; k >= 0; k--) begin
      if (v[k] && cur_fm[k]) begin
        v[k] = 1'b0;
        if (commit) m_kill++;
      end else if (v[k] && k == S - 1) begin
        if (cur_ordy) v[k] = 1'b0;
      end else if (v[k] && k < S - 1) begin
        if (!v[k+1]) begin
          v[k+1]  = 1'b1;
          dd[k+1] = dd[k];
          v[k]    = 1'b0;
        end
      end
    end
    free0 = !v[0];
    if (commit) begin
      if (cur_iv && free0) begin
        v[0]  = 1'b1;
        dd[0] = cur_id;
      end
      if (cur_iv && !free0) m_stall++;
      mv = v;
      md = dd;
    end
    return free0;
  endfunction

  function automatic int exp_occ();
    int n = 0;
    for (int k = 0; k < S; k++) n += int'(mv[k]);
    return n;
  endfunction

  function automatic logic exp_ov();
    return mv[S-1] && !cur_fm[S-1];
  endfunction

  task automatic drive(input logic iv, input logic [W-1:0] id,
                       input logic [S-1:0] fm, input logic ordy);
    cur_iv = iv; cur_id = id; cur_fm = fm; cur_ordy = ordy;
    in_if.valid  = iv;
    in_if.data   = id;
    flush_mask   = fm;
    out_if.ready = ordy;
    #1;
  endtask

  task automatic tick();
    if (out_if.valid && out_if.ready) seen.push_back(out_if.data);
    void'(model_advance(1'b1));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2 * S; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 1'b1);
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_if.valid); end
    n_cmp++; if (out_if.data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_if.data); end
    n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_if.ready); end
    n_cmp++; if (occupancy !== '0) begin n_bad++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
`ifdef PIPE_CHAIN_PERF_EN
    n_cmp++; if (perf_stall_cnt !== 16'h0 || perf_kill_cnt !== 16'h0) begin
      n_bad++; $display("FAIL reset_perf: got %h/%h want 0000/0000", perf_stall_cnt, perf_kill_cnt);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_streaming();
    int first = -1;
    seen.delete();
    for (int i = 0; i < 16; i++) begin
      drive(i < 8, W'(i + 1), '0, 1'b1);
      if (out_if.valid === 1'b1 && first < 0) first = i;
      n_cmp++; if (out_if.valid !== exp_ov() || (exp_ov() && out_if.data !== md[S-1])) begin
        n_bad++; $display("FAIL stream_out cyc%0d: got v=%b d=%h want v=%b d=%h", i, out_if.valid, out_if.data, exp_ov(), md[S-1]);
      end
      tick();
    end
    n_cmp++; if (first != S) begin n_bad++; $display("FAIL stream_latency: got %0d want %0d", first, S); end
    n_cmp++; if (seen.size() != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", seen.size()); end
    for (int i = 0; i < 8 && i < seen.size(); i++) begin
      n_cmp++; if (seen[i] !== W'(i + 1)) begin n_bad++; $display("FAIL stream_order[%0d]: got %h want %h", i, seen[i], W'(i + 1)); end
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < S; i++) begin
      drive(1'b1, W'(16'h1111 * (i + 1)), '0, 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'hDEAD, '0, 1'b0);
      n_cmp++; if (in_if.ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", i, in_if.ready); end
      n_cmp++; if (occupancy !== OW'(S)) begin n_bad++; $display("FAIL bp_occupancy cyc%0d: got %0d want %0d", i, occupancy, S); end
      n_cmp++; if (out_if.valid !== 1'b1 || out_if.data !== 16'h1111) begin
        n_bad++; $display("FAIL bp_hold cyc%0d: got v=%b d=%h want v=1 d=1111", i, out_if.valid, out_if.data);
      end
      tick();
    end
    for (int i = 0; i < S; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_cmp++; if (out_if.valid !== 1'b1 || out_if.data !== W'(16'h1111 * (i + 1))) begin
        n_bad++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_if.valid, out_if.data, W'(16'h1111 * (i + 1)));
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [W-1:0] items [4];
    items = '{16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A};
    drain();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, items[i], '0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 4'b0110, 1'b0);
    tick();
    n_cmp++; if (occupancy !== OW'(2)) begin n_bad++; $display("FAIL flush_occupancy: got %0d want 2", occupancy); end
`ifdef PIPE_CHAIN_PERF_EN
    n_cmp++; if (perf_kill_cnt !== 16'(m_kill) || m_kill != 2) begin
      n_bad++; $display("FAIL flush_kill_cnt: got %0d want 2", perf_kill_cnt);
    end
`endif
    seen.delete();
    drain();
    n_cmp++; if (seen.size() != 2 || seen[0] !== 16'hD00D || seen[1] !== 16'hA00A) begin
      n_bad++; $display("FAIL flush_order: got n=%0d first=%h want n=2 D00D,A00A", seen.size(), (seen.size() > 0) ? seen[0] : 16'hXXXX);
    end
  endtask

  task automatic test_flush_accept();
    for (int i = 0; i < S; i++) begin
      drive(1'b1, W'(16'h2000 + i), '0, 1'b0);
      tick();
    end
    drive(1'b1, 16'hBEEF, 4'b1111, 1'b0);
    n_cmp++; if (in_if.ready !== 1'b1) begin n_bad++; $display("FAIL fa_in_ready: got %b want 1", in_if.ready); end
    n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL fa_out_valid: got %b want 0", out_if.valid); end
    tick();
    n_cmp++; if (occupancy !== OW'(1)) begin n_bad++; $display("FAIL fa_occupancy: got %0d want 1", occupancy); end
    seen.delete();
    drain();
    n_cmp++; if (seen.size() != 1 || seen[0] !== 16'hBEEF) begin
      n_bad++; $display("FAIL fa_output: got n=%0d want 1 item BEEF", seen.size());
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(16'h3000 + i), '0, 1'b1);
      tick();
    end
    reset_n = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (out_if.valid !== 1'b0 || occupancy !== '0) begin
      n_bad++; $display("FAIL mid_reset: got v=%b occ=%0d want v=0 occ=0", out_if.valid, occupancy);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 16'h5A5A, '0, 1'b1);
    tick();
    for (int i = 1; i < S; i++) begin
      drive(1'b0, '0, '0, 1'b1);
      n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL mid_early cyc%0d: got %b want 0", i, out_if.valid); end
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    n_cmp++; if (out_if.valid !== 1'b1 || out_if.data !== 16'h5A5A) begin
      n_bad++; $display("FAIL mid_after: got v=%b d=%h want v=1 d=5A5A", out_if.valid, out_if.data);
    end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [S-1:0] fm;
      fm = ($urandom_range(0, 7) == 0) ? S'($urandom) : '0;
      drive(1'($urandom_range(0, 3) != 0), W'($urandom), fm, 1'($urandom_range(0, 2) != 0));
      n_cmp++; if (in_if.ready !== model_advance(1'b0)) begin
        n_bad++; $display("FAIL rnd_in_ready cyc%0d: got %b want %b", i, in_if.ready, model_advance(1'b0));
      end
      n_cmp++; if (out_if.valid !== exp_ov() || (exp_ov() && out_if.data !== md[S-1])) begin
        n_bad++; $display("FAIL rnd_out cyc%0d: got v=%b d=%h want v=%b d=%h", i, out_if.valid, out_if.data, exp_ov(), md[S-1]);
      end
      n_cmp++; if (occupancy !== OW'(exp_occ())) begin
        n_bad++; $display("FAIL rnd_occupancy cyc%0d: got %0d want %0d", i, occupancy, exp_occ());
      end
`ifdef PIPE_CHAIN_PERF_EN
      n_cmp++; if (perf_stall_cnt !== 16'(m_stall) || perf_kill_cnt !== 16'(m_kill)) begin
        n_bad++; $display("FAIL rnd_perf cyc%0d: got %0d/%0d want %0d/%0d", i, perf_stall_cnt, perf_kill_cnt, m_stall, m_kill);
      end
`endif
      tick();
    end
  endtask

`ifdef PIPE_CHAIN_PERF_EN
  task automatic test_saturation();
    for (int i = 0; i < S; i++) begin
      drive(1'b1, W'(i), '0, 1'b0);
      tick();
    end
    for (int i = 0; i < 70000; i++) begin
      drive(1'b1, '0, '0, 1'b0);
      tick();
    end
    n_cmp++; if (perf_stall_cnt !== 16'hFFFF || m_stall < 65535) begin
      n_bad++; $display("FAIL sat_stall: got %h want FFFF", perf_stall_cnt);
    end
    repeat (3) begin
      drive(1'b1, '0, '0, 1'b0);
      tick();
    end
    n_cmp++; if (perf_stall_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL sat_hold: got %h want FFFF", perf_stall_cnt); end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    model_reset();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_flush_accept();
    test_reset_midstream();
    test_random();
`ifdef PIPE_CHAIN_PERF_EN
    test_saturation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
